point_stream_decoder: RTL and testbench

//  Turns the UART byte stream into buffered vector commands for the line-draw controller.

---
 rtl/vectorfpga_pkg.sv | 17 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/point_stream_decoder.sv | 142 ++++++++++++++
 tb/tb_point_stream_decoder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vectorfpga_pkg.sv
// Shared constants for the vectorfpga stream path.
//   OP_JUMP / OP_DRAW : point-word opcodes that produce a command
//   ST_IDLE / ST_STREAM : assembler state encodings
//   fifo_w()          : width of one queued command {draw, x, y}
package vectorfpga_pkg;

   localparam logic [1:0] OP_JUMP = 2'b00;
   localparam logic [1:0] OP_DRAW = 2'b01;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   function automatic int fifo_w(input int coord_w);
      return 2 * coord_w + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request; dout updates on the edge that pops
//   full, empty, level : occupancy status
module sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             do_push, do_pop;

   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == (AW+1)'(DEPTH));
      do_pop   = pop && !empty;
      // A push at full is accepted only when a pop frees the slot in the same cycle.
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      dout_d   = do_pop  ? mem_q[rd_ptr_q]   : dout_q;
      level_d  = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = dout_q;
   assign level = level_q;

endmodule

// File: rtl/point_stream_decoder.sv
// Turns the UART byte stream into queued jump/draw commands for the
// line-draw controller.
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid, rx_byte   : received byte strobe and data
//   ready               : controller can accept a command
//   x, y, draw, jump    : command output; draw/jump are one-cycle pulses
//   streaming           : assembler is inside a frame
//   frame_done          : one-cycle pulse on a done word
//   fifo_level          : command FIFO occupancy
//   overflow            : sticky, a command was dropped on a full FIFO
module point_stream_decoder
   import vectorfpga_pkg::*;
#(
   parameter int         COORD_W         = 12,
   parameter int         BYTES_PER_POINT = 4,
   parameter int         FIFO_DEPTH      = 16,
   parameter logic [7:0] DONE_BYTE       = 8'h01
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_byte,
   input  logic                          ready,
   output logic [COORD_W-1:0]            x,
   output logic [COORD_W-1:0]            y,
   output logic                          draw,
   output logic                          jump,
   output logic                          streaming,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int W  = 8 * BYTES_PER_POINT;
   localparam int FW = fifo_w(COORD_W);
   localparam int CW = (BYTES_PER_POINT > 1) ? $clog2(BYTES_PER_POINT) : 1;
   localparam logic [CW-1:0] LAST_IDX  = CW'(BYTES_PER_POINT - 1);
   localparam logic [W-1:0]  DONE_WORD = {BYTES_PER_POINT{DONE_BYTE}};

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // Only the earlier BYTES_PER_POINT-1 bytes need storing; the last byte
   // is taken straight from rx_byte when the word completes.
   logic [W-9:0]  sr_q, sr_d;
   logic          push_q, push_d;
   logic [FW-1:0] entry_q, entry_d;
   logic          frame_done_q, frame_done_d;
   logic          issue_q, issue_d;
   logic          overflow_q, overflow_d;

   logic [W-1:0]  word;
   logic [1:0]    op;
   logic          pop;
   logic          fifo_full, fifo_empty;
   logic [FW-1:0] fifo_dout;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      push_d       = 1'b0;
      entry_d      = entry_q;
      frame_done_d = 1'b0;
      word         = {sr_q, rx_byte};
      op           = word[W-1:W-2];

      if (rx_valid) begin
         if (state_q == ST_IDLE) begin
            if (rx_byte != '0) begin
               state_d = ST_STREAM;
               cnt_d   = '0;
            end
         end else begin
            sr_d = word[W-9:0];
            if (cnt_q == LAST_IDX) begin
               cnt_d = '0;
               if (word == DONE_WORD) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end else if (op == OP_JUMP || op == OP_DRAW) begin
                  push_d  = 1'b1;
                  entry_d = {op[0], word[2*COORD_W-1:COORD_W], word[COORD_W-1:0]};
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // issue_q marks the pulse cycle, which blocks the next pop and forces an idle gap.
      pop        = !fifo_empty && ready && !issue_q;
      issue_d    = pop;
      overflow_d = overflow_q | (push_q && fifo_full && !pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         push_q       <= 1'b0;
         entry_q      <= '0;
         frame_done_q <= 1'b0;
         issue_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         push_q       <= push_d;
         entry_q      <= entry_d;
         frame_done_q <= frame_done_d;
         issue_q      <= issue_d;
         overflow_q   <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .pop   (pop),
      .din   (entry_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // x/y come straight from the FIFO read register, so they hold between commands.
   assign x          = fifo_dout[2*COORD_W-1:COORD_W];
   assign y          = fifo_dout[COORD_W-1:0];
   assign draw       = issue_q &  fifo_dout[2*COORD_W];
   assign jump       = issue_q & ~fifo_dout[2*COORD_W];
   assign streaming  = (state_q == ST_STREAM);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_point_stream_decoder.sv
module tb_point_stream_decoder;

   localparam int COORD_W = 12;
   localparam int BPP     = 4;
   localparam int DEPTH   = 16;
   localparam int LW      = $clog2(DEPTH) + 1;
   localparam logic [7:0] DONE = 8'h01;

   logic          clk = 1'b0;
   logic          reset, rx_valid, ready;
   logic [7:0]    rx_byte;
   logic [11:0]   x, y;
   logic          draw, jump, streaming, frame_done, overflow;
   logic [LW-1:0] fifo_level;

   always #5 clk = ~clk;

   point_stream_decoder #(
      .COORD_W         (COORD_W),
      .BYTES_PER_POINT (BPP),
      .FIFO_DEPTH      (DEPTH),
      .DONE_BYTE       (DONE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .ready      (ready),
      .x          (x),
      .y          (y),
      .draw       (draw),
      .jump       (jump),
      .streaming  (streaming),
      .frame_done (frame_done),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   typedef struct { logic [11:0] x; logic [11:0] y; logic d; } cmd_t;
   typedef struct { logic [11:0] x; logic [11:0] y; logic d; logic j; int cyc; } pulse_t;

   // reference model state
   cmd_t       m_exp[$];
   logic [7:0] m_bytes[$];
   bit         m_stream;
   bit         m_ovf;
   int         m_held;
   int         m_frames;

   // observations
   pulse_t obs[$];
   int     fd_cnt = 0;
   int     cyc = 0;

   int n_checks = 0;
   int n_pass   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pulse_t p;
      if (draw || jump) begin
         p.x = x; p.y = y; p.d = draw; p.j = jump; p.cyc = cyc;
         obs.push_back(p);
      end
      if (frame_done) fd_cnt++;
   end

   // Byte-level reference: collect bytes, form the word, classify it.
   task automatic model_byte(input logic [7:0] b, input bit coincide);
      logic [31:0] w;
      bit          all_done;
      cmd_t        c;
      if (!m_stream) begin
         if (b != 8'h00) m_stream = 1'b1;
         return;
      end
      m_bytes.push_back(b);
      if (m_bytes.size() < BPP) return;
      w = '0;
      all_done = 1'b1;
      foreach (m_bytes[i]) begin
         w = (w << 8) | {24'h0, m_bytes[i]};
         if (m_bytes[i] != DONE) all_done = 1'b0;
      end
      m_bytes.delete();
      if (all_done) begin
         m_stream = 1'b0;
         m_frames++;
      end else if (w[31:30] < 2'd2) begin
         if (m_held >= DEPTH && !coincide) begin
            m_ovf = 1'b1;
         end else begin
            c.x = w[23:12]; c.y = w[11:0]; c.d = w[30];
            m_exp.push_back(c);
            if (!ready) m_held++;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit coincide = 1'b0);
      model_byte(b, coincide);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = $urandom_range(0, 255);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int unsigned i = 0; i < BPP; i++) begin
         send_byte(w[31-8*i -: 8]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   function automatic logic [31:0] mk_word(input logic [1:0] op);
      logic [5:0]  pad;
      logic [11:0] cx, cy;
      pad = 6'($urandom);
      cx  = 12'($urandom);
      cy  = 12'($urandom);
      return {op, pad, cx, cy};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = 8'hAA;
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      m_stream = 1'b0; m_ovf = 1'b0; m_held = 0; m_frames = 0;
      m_bytes.delete(); m_exp.delete(); obs.delete();
      fd_cnt = 0;
   endtask

   task automatic drain(output bit ok);
      int n = 0;
      while ((fifo_level != 0 || draw || jump) && n < 600) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      ok = (n < 600);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({x, y, draw, jump, streaming, frame_done, fifo_level, overflow} !== '0)
         $display("FAIL reset_outputs got x=%h y=%h d=%b j=%b s=%b fd=%b lvl=%0d ovf=%b required all 0",
                  x, y, draw, jump, streaming, frame_done, fifo_level, overflow);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (streaming !== 1'b0) $display("FAIL reset_rx_ignored got streaming=%b required 0", streaming);
      else n_pass++;
   endtask

   task automatic test_draw();
      bit ok;
      do_reset();
      ready = 1'b1;
      send_byte(8'hAA);
      send_word(32'h4000_1234);
      drain(ok);
      n_checks++;
      if (!ok || streaming !== 1'b1) $display("FAIL draw_stream got ok=%b streaming=%b required 1/1", ok, streaming);
      else n_pass++;
      n_checks++;
      if (obs.size() != 1 || m_exp.size() != 1) $display("FAIL draw_count got %0d pulses required 1", obs.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL draw_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
      end
      n_checks++;
      if (x !== 12'h001 || y !== 12'h234) $display("FAIL draw_hold got x=%h y=%h required 001/234", x, y);
      else n_pass++;
   endtask

   task automatic test_jump_done();
      bit ok;
      do_reset();
      ready = 1'b1;
      send_byte(8'hAA);
      send_word(32'h0000_0506);
      send_word(32'h0101_0101);
      drain(ok);
      n_checks++;
      if (!ok || fd_cnt != 1 || streaming !== 1'b0)
         $display("FAIL jump_frame_done got ok=%b fd=%0d streaming=%b required 1/1/0", ok, fd_cnt, streaming);
      else n_pass++;
      n_checks++;
      if (obs.size() != m_exp.size() || obs.size() != 1) $display("FAIL jump_count got %0d pulses required 1", obs.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL jump_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
      end
      n_checks++;
      if (x !== 12'h000 || y !== 12'h506) $display("FAIL jump_hold got x=%h y=%h required 000/506", x, y);
      else n_pass++;
   endtask

   task automatic test_overflow();
      bit ok;
      do_reset();
      ready = 1'b0;
      send_byte(8'hAA);
      for (int i = 0; i < 17; i++) send_word(mk_word(2'b01));
      repeat (3) @(negedge clk);
      n_checks++;
      if (fifo_level !== LW'(16) || overflow !== 1'b1 || m_ovf != 1'b1)
         $display("FAIL ovf_full got level=%0d overflow=%b required 16/1", fifo_level, overflow);
      else n_pass++;
      ready = 1'b1;
      drain(ok);
      n_checks++;
      if (!ok || obs.size() != m_exp.size() || obs.size() != 16)
         $display("FAIL ovf_count got ok=%b pulses=%0d required 16", ok, obs.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL ovf_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
         if (i > 0) begin
            n_checks++;
            if (obs[i].cyc - obs[i-1].cyc < 2)
               $display("FAIL ovf_gap%0d got spacing %0d required >=2", i, obs[i].cyc - obs[i-1].cyc);
            else n_pass++;
         end
      end
   endtask

   task automatic test_idle_reserved();
      do_reset();
      ready = 1'b1;
      send_byte(8'h00);
      send_byte(8'h00);
      n_checks++;
      if (streaming !== 1'b0) $display("FAIL idle_zero got streaming=%b required 0", streaming);
      else n_pass++;
      send_byte(8'h55);
      n_checks++;
      if (streaming !== 1'b1) $display("FAIL idle_sync got streaming=%b required 1", streaming);
      else n_pass++;
      send_word(32'h8000_0000);
      repeat (4) @(negedge clk);
      n_checks++;
      if (fifo_level !== '0 || obs.size() != 0 || overflow !== 1'b0 || streaming !== 1'b1 || m_exp.size() != 0)
         $display("FAIL reserved_drop got level=%0d pulses=%0d overflow=%b streaming=%b required 0/0/0/1",
                  fifo_level, obs.size(), overflow, streaming);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      bit          ok;
      logic [31:0] w;
      do_reset();
      ready = 1'b0;
      send_byte(8'hAA);
      for (int i = 0; i < 3; i++) send_word(mk_word(2'($urandom_range(0, 1))));
      w = mk_word(2'b01);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      repeat (2) @(negedge clk);
      n_checks++;
      if (fifo_level !== LW'(3)) $display("FAIL mid_setup got level=%0d required 3", fifo_level);
      else n_pass++;
      do_reset();
      n_checks++;
      if ({x, y, draw, jump, streaming, frame_done, fifo_level, overflow} !== '0)
         $display("FAIL mid_reset got x=%h y=%h d=%b j=%b s=%b fd=%b lvl=%0d ovf=%b required all 0",
                  x, y, draw, jump, streaming, frame_done, fifo_level, overflow);
      else n_pass++;
      ready = 1'b1;
      send_byte(8'h3C);
      send_word(mk_word(2'($urandom_range(0, 1))));
      drain(ok);
      n_checks++;
      if (!ok || obs.size() != m_exp.size() || obs.size() != 1)
         $display("FAIL mid_count got ok=%b pulses=%0d required 1", ok, obs.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL mid_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back_full();
      bit          ok;
      logic [31:0] w;
      do_reset();
      ready = 1'b0;
      send_byte(8'hAA);
      for (int i = 0; i < 16; i++) send_word(mk_word(2'($urandom_range(0, 1))));
      w = mk_word(2'($urandom_range(0, 1)));
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      n_checks++;
      if (fifo_level !== LW'(16) || overflow !== 1'b0)
         $display("FAIL full_setup got level=%0d overflow=%b required 16/0", fifo_level, overflow);
      else n_pass++;
      // last byte lands so that its push and the first pop share one edge
      send_byte(w[7:0], 1'b1);
      ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fifo_level !== LW'(16) || overflow !== 1'b0)
         $display("FAIL full_coincide got level=%0d overflow=%b required 16/0", fifo_level, overflow);
      else n_pass++;
      drain(ok);
      n_checks++;
      if (!ok || obs.size() != m_exp.size() || obs.size() != 17 || overflow !== 1'b0)
         $display("FAIL full_count got ok=%b pulses=%0d overflow=%b required 17/0", ok, obs.size(), overflow);
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL full_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      bit ok;
      int r;
      do_reset();
      ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (!m_stream) begin
            repeat ($urandom_range(0, 1)) send_byte(8'h00);
            send_byte(8'($urandom_range(1, 255)));
         end
         r = $urandom_range(0, 9);
         if (r == 0)      send_word(32'h0101_0101);
         else if (r == 1) send_word(mk_word(2'($urandom_range(2, 3))));
         else             send_word(mk_word(2'($urandom_range(0, 1))));
      end
      drain(ok);
      n_checks++;
      if (!ok || fd_cnt != m_frames || overflow !== 1'b0 || streaming !== m_stream)
         $display("FAIL rand_status got ok=%b fd=%0d overflow=%b streaming=%b required fd=%0d ovf=0 streaming=%b",
                  ok, fd_cnt, overflow, streaming, m_frames, m_stream);
      else n_pass++;
      n_checks++;
      if (obs.size() != m_exp.size()) $display("FAIL rand_count got %0d pulses required %0d", obs.size(), m_exp.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < m_exp.size(); i++) begin
         n_checks++;
         if ({obs[i].x, obs[i].y, obs[i].d, obs[i].j} !== {m_exp[i].x, m_exp[i].y, m_exp[i].d, ~m_exp[i].d})
            $display("FAIL rand_cmd%0d got x=%h y=%h d=%b j=%b required x=%h y=%h d=%b",
                     i, obs[i].x, obs[i].y, obs[i].d, obs[i].j, m_exp[i].x, m_exp[i].y, m_exp[i].d);
         else n_pass++;
      end
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      ready    = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_draw();
      test_jump_done();
      test_overflow();
      test_idle_reserved();
      test_reset_midframe();
      test_back_to_back_full();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
